// File: rtl/multicycle_ctrl_if.sv
// Unified memory port shared by instruction fetch and load/store.
// mem_req/mem_we/iord are held stable by the controller until the cycle mem_ready=1; that cycle completes the transfer.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multi-cycle datapath with one shared memory port.
// Drives datapath selects/enables per state and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  multicycle_ctrl_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_q;
  state_t           state_d;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign retired = retired_q;

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    state_o       = state_q;

    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        // IR and PC load only in the cycle the fetch actually completes
        ir_write    = mem.mem_ready;
        pc_write    = mem.mem_ready;
        if (mem.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_SW) state_d = S_MEMWR;
        else if (opcode == OP_LW) state_d = S_MEMRD;
        else state_d = S_FETCH;
      end
      S_MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every control output, including an in-flight memory request
    if (reset) begin
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.iord      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal       = 1'b0;
      state_o       = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle vectors of inputs and expected
// state/controls/retire count, plus a counter wrap sequence on a narrow instance.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        ir_write, pc_write, pc_write_cond, alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [3:0]  state_o;
  logic [31:0] retired;

  logic        reset2;
  logic [5:0]  opcode2;
  logic        w_ir_write, w_pc_write, w_pc_write_cond, w_alu_src_a, w_reg_write, w_reg_dst, w_mem_to_reg, w_illegal;
  logic [1:0]  w_pc_src, w_alu_src_b, w_alu_op;
  logic [3:0]  w_state_o;
  logic [2:0]  w_retired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if mem ();
  multicycle_ctrl_if mem2 ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem(mem.master),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .state_o(state_o), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(3)) dut_w (
    .clk(clk), .reset(reset2), .opcode(opcode2), .mem(mem2.master),
    .ir_write(w_ir_write), .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond),
    .pc_src(w_pc_src), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
    .reg_write(w_reg_write), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .illegal(w_illegal), .state_o(w_state_o), .retired(w_retired)
  );

  // {mem_req,mem_we,iord}_{ir_write,pc_write,pc_write_cond}_pc_src_alu_src_a_alu_src_b_alu_op_{reg_write,reg_dst,mem_to_reg,illegal}
  localparam logic [16:0] C_ZERO    = 17'b000_000_00_0_00_00_0000;
  localparam logic [16:0] C_FETCH0  = 17'b100_000_00_0_01_00_0000;
  localparam logic [16:0] C_FETCH1  = 17'b100_110_00_0_01_00_0000;
  localparam logic [16:0] C_DECODE  = 17'b000_000_00_0_11_00_0000;
  localparam logic [16:0] C_DEC_ILL = 17'b000_000_00_0_11_00_0001;
  localparam logic [16:0] C_MEMADR  = 17'b000_000_00_1_10_00_0000;
  localparam logic [16:0] C_MEMRD   = 17'b101_000_00_0_00_00_0000;
  localparam logic [16:0] C_MEMWB   = 17'b000_000_00_0_00_00_1010;
  localparam logic [16:0] C_MEMWR   = 17'b111_000_00_0_00_00_0000;
  localparam logic [16:0] C_EXEC    = 17'b000_000_00_1_00_10_0000;
  localparam logic [16:0] C_ALUWB   = 17'b000_000_00_0_00_00_1100;
  localparam logic [16:0] C_BRANCH  = 17'b000_001_01_1_00_01_0000;
  localparam logic [16:0] C_ADDIEX  = 17'b000_000_00_1_10_00_0000;
  localparam logic [16:0] C_ADDIWB  = 17'b000_000_00_0_00_00_1000;
  localparam logic [16:0] C_JUMP    = 17'b000_010_10_0_00_00_0000;

  localparam logic [5:0] OPR = 6'b000000;
  localparam logic [5:0] OLW = 6'b100011;
  localparam logic [5:0] OSW = 6'b101011;
  localparam logic [5:0] OBQ = 6'b000100;
  localparam logic [5:0] OAD = 6'b001000;
  localparam logic [5:0] OJ  = 6'b000010;
  localparam logic [5:0] OIL = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [16:0] exp_ctrl;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [5:0] op, logic rdy, logic [3:0] st, logic [16:0] c, logic [31:0] r);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.exp_state = st; v.exp_ctrl = c; v.exp_ret = r;
    return v;
  endfunction

  function automatic logic [16:0] ctrl_now();
    return {mem.mem_req, mem.mem_we, mem.iord, ir_write, pc_write, pc_write_cond, pc_src,
            alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // reset check, then R-type
    vecs.push_back(mk(1, OPR, 1, 0,  C_ZERO,    0));
    vecs.push_back(mk(0, OPR, 1, 0,  C_FETCH1,  0));
    vecs.push_back(mk(0, OPR, 1, 1,  C_DECODE,  0));
    vecs.push_back(mk(0, OPR, 1, 6,  C_EXEC,    0));
    vecs.push_back(mk(0, OPR, 1, 7,  C_ALUWB,   0));
    // lw with three wait cycles in MEMRD
    vecs.push_back(mk(0, OLW, 1, 0,  C_FETCH1,  1));
    vecs.push_back(mk(0, OLW, 1, 1,  C_DECODE,  1));
    vecs.push_back(mk(0, OLW, 1, 2,  C_MEMADR,  1));
    vecs.push_back(mk(0, OLW, 0, 3,  C_MEMRD,   1));
    vecs.push_back(mk(0, OLW, 0, 3,  C_MEMRD,   1));
    vecs.push_back(mk(0, OLW, 0, 3,  C_MEMRD,   1));
    vecs.push_back(mk(0, OLW, 1, 3,  C_MEMRD,   1));
    vecs.push_back(mk(0, OLW, 1, 4,  C_MEMWB,   1));
    // sw, beq, j zero-wait
    vecs.push_back(mk(0, OSW, 1, 0,  C_FETCH1,  2));
    vecs.push_back(mk(0, OSW, 1, 1,  C_DECODE,  2));
    vecs.push_back(mk(0, OSW, 1, 2,  C_MEMADR,  2));
    vecs.push_back(mk(0, OSW, 1, 5,  C_MEMWR,   2));
    vecs.push_back(mk(0, OBQ, 1, 0,  C_FETCH1,  3));
    vecs.push_back(mk(0, OBQ, 1, 1,  C_DECODE,  3));
    vecs.push_back(mk(0, OBQ, 1, 8,  C_BRANCH,  3));
    vecs.push_back(mk(0, OJ,  1, 0,  C_FETCH1,  4));
    vecs.push_back(mk(0, OJ,  1, 1,  C_DECODE,  4));
    vecs.push_back(mk(0, OJ,  1, 11, C_JUMP,    4));
    // addi with two fetch wait cycles
    vecs.push_back(mk(0, OAD, 0, 0,  C_FETCH0,  5));
    vecs.push_back(mk(0, OAD, 0, 0,  C_FETCH0,  5));
    vecs.push_back(mk(0, OAD, 1, 0,  C_FETCH1,  5));
    vecs.push_back(mk(0, OAD, 0, 1,  C_DECODE,  5));
    vecs.push_back(mk(0, OAD, 1, 9,  C_ADDIEX,  5));
    vecs.push_back(mk(0, OAD, 1, 10, C_ADDIWB,  5));
    // illegal opcode: one DECODE cycle, no retire
    vecs.push_back(mk(0, OIL, 1, 0,  C_FETCH1,  6));
    vecs.push_back(mk(0, OIL, 1, 1,  C_DEC_ILL, 6));
    // sw stalled in MEMWR, then reset mid-wait
    vecs.push_back(mk(0, OSW, 0, 0,  C_FETCH0,  6));
    vecs.push_back(mk(0, OSW, 1, 0,  C_FETCH1,  6));
    vecs.push_back(mk(0, OSW, 1, 1,  C_DECODE,  6));
    vecs.push_back(mk(0, OSW, 0, 2,  C_MEMADR,  6));
    vecs.push_back(mk(0, OSW, 0, 5,  C_MEMWR,   6));
    vecs.push_back(mk(1, OSW, 0, 0,  C_ZERO,    6));
    vecs.push_back(mk(0, OSW, 0, 0,  C_FETCH0,  0));

    reset = 1'b1; opcode = OPR; mem.mem_ready = 1'b1;
    reset2 = 1'b1; opcode2 = OPR; mem2.mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      opcode = vecs[i].op;
      mem.mem_ready = vecs[i].rdy;
      #1;
      check32($sformatf("row%0d state", i), {28'd0, state_o}, {28'd0, vecs[i].exp_state});
      check32($sformatf("row%0d ctrl", i), {15'd0, ctrl_now()}, {15'd0, vecs[i].exp_ctrl});
      check32($sformatf("row%0d retired", i), retired, vecs[i].exp_ret);
    end

    // Narrow counter: R-type takes 4 cycles zero-wait, so 7 and 8 instructions
    @(negedge clk);
    reset2 = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    check32("wrap pre", {29'd0, w_retired}, 32'd7);
    check32("wrap state pre", {28'd0, w_state_o}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check32("wrap post", {29'd0, w_retired}, 32'd0);
    check32("wrap state post", {28'd0, w_state_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences the processor datapath as a multi-cycle machine. It replaces the single-cycle control path and shares one unified memory port between instruction fetch and load/store. The block decodes the opcode once per instruction and drives all datapath mux selects and write enables cycle by cycle. It stalls on a memory ready handshake and counts retired instructions.

## Interface
- Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.
- Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  instruction[31:26], valid from DECODE onward (IR output).
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU Zero.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  0 = PC, 1 = reg A.
- `alu_src_b`  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = use funct.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR.
- `illegal`  out  1  unsupported opcode seen in DECODE.
- `state_o`  out  4  current state encoding (debug).
- `retired`  out  CNT_W  retired-instruction count.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and go to FETCH.
- Any output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. `ir_write` and `pc_write` equal `mem_ready`. Goes to DECODE on `mem_ready`; otherwise holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Transitions by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - other → FETCH, with `illegal`=1 this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if lw, MEMWR if sw.
- MEMRD: mem_req=1, iord=1. Goes to MEMWB on `mem_ready`; otherwise holds.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Goes to FETCH on `mem_ready`; otherwise holds.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- Retire counter:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP.
  - An illegal opcode does not retire.
  - Wraps modulo 2^CNT_W without a flag.

## Timing
- Reset:
  - The state register goes to FETCH and `retired` clears to 0 at the first rising edge with `reset`=1.
  - While `reset`=1, every control output is forced to 0, including `mem_req`. `state_o` reads 0.
  - Reset during a memory wait drops `mem_req` in the cycle reset is sampled.
  - The first FETCH request is issued in the cycle after `reset` deasserts.
- Outputs are combinational from the state register only, except that `ir_write`/`pc_write` in FETCH are gated by `mem_ready` and `illegal` depends on `opcode`. There is no input-to-state combinational loop.
- Memory handshake: in a requesting state, `mem_req`/`mem_we`/`iord` stay stable until the cycle where `mem_ready`=1. The transfer completes in that cycle. `mem_ready` outside a requesting state is ignored.
- Latency with zero-wait memory (mem_ready tied high), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each wait cycle adds 1.
- `opcode` is sampled only in DECODE and MEMADR. It must be stable from the cycle after IR load until the instruction returns to FETCH.

## Test plan
- Reset release, `mem_ready`=1, opcode=000000: `state_o` sequence 0,1,6,7,0. `reg_write`=1 and `reg_dst`=1 only in state 7. `retired` goes to 1.
- lw with `mem_ready` low for 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0. `mem_req`=1 and `iord`=1 throughout the MEMRD cycles. `mem_to_reg`=1 only in MEMWB.
- sw, then beq, then j, zero-wait: state sequence 0,1,2,5,0,1,8,0,1,11,0. `mem_we`=1 only in MEMWR, `pc_write_cond`=1 with `pc_src`=01 in BRANCH, `pc_write`=1 with `pc_src`=10 in JUMP. `retired`=3.
- FETCH with `mem_ready`=0 for 2 cycles: `ir_write`=0 and `pc_write`=0 for those cycles, then a 1-cycle pulse of both in the ready cycle.
- opcode=111111: `illegal`=1 for exactly the DECODE cycle, back to FETCH next cycle, `retired` unchanged.
- Reset asserted mid-MEMWR wait: `mem_req`/`mem_we` are 0 in the same cycle, FETCH after release, `retired`=0. Separately, preloading `retired`=2^32−1 then retiring one instruction gives 0.
